stopwatch_timer_dp: RTL and testbench

Parametrised successor datapath for the stopwatch. It counts hours:minutes:seconds:centiseconds up as a stopwatch, or down as a countdown timer with preload. It captures a lap/split snapshot and muxes either live or lap time onto the two display fields. It sits between the button/FSM control unit and the FND display controller. Run/stop uses a synchronous enable, never a gated clock.

---
 rtl/stopwatch_timer_dp_pkg.sv | 25 ++
 rtl/stopwatch_timer_dp_time_field_counter.sv | 36 +++
 rtl/stopwatch_timer_dp.sv | 120 ++++++++++++
 tb/tb_stopwatch_timer_dp.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_timer_dp_pkg.sv
// stopwatch_pkg: shared field moduli, field widths, time record type and prescale helper
package stopwatch_pkg;

   localparam int MSEC_MOD = 100;
   localparam int SEC_MOD  = 60;
   localparam int MIN_MOD  = 60;
   localparam int HOUR_MOD = 24;

   localparam int MSEC_W = 7;
   localparam int SEC_W  = 6;
   localparam int MIN_W  = 6;
   localparam int HOUR_W = 5;

   typedef struct packed {
      logic [HOUR_W-1:0] hour;
      logic [MIN_W-1:0]  minute;
      logic [SEC_W-1:0]  second;
      logic [MSEC_W-1:0] msec;
   } sw_time_t;

   function automatic int calc_div(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

endpackage

// File: rtl/stopwatch_timer_dp_time_field_counter.sv
// time_field_counter: one modulo-MAX time field with saturating preload and combinational carry/borrow out
module time_field_counter #(
   parameter int MAX   = 60,
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr,
   output logic [WIDTH-1:0] value,
   output logic             co
);

   localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX - 1);

   logic [WIDTH-1:0] r_val;

   assign value = r_val;
   assign co    = en & (dir ? (r_val == '0) : (r_val == TOP));

   // Field register: clear beats load beats a count step; up wraps at TOP, down reloads TOP at 0
   always_ff @(posedge clk or posedge rst)
      if (rst)
         r_val <= '0;
      else if (clr)
         r_val <= '0;
      else if (load)
         r_val <= (load_val > TOP) ? TOP : load_val;
      else if (en)
         r_val <= dir ? ((r_val == '0) ? TOP : r_val - 1'b1)
                      : ((r_val == TOP) ? '0 : r_val + 1'b1);

endmodule

// File: rtl/stopwatch_timer_dp.sv
// stopwatch_timer_dp: up/down hh:mm:ss.cc datapath with prescaler, lap capture and display mux
module stopwatch_timer_dp
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ   = 100_000_000,
   parameter int TICK_HZ  = 100,
   parameter int MSEC_MAX = MSEC_MOD,
   parameter int SEC_MAX  = SEC_MOD,
   parameter int MIN_MAX  = MIN_MOD,
   parameter int HOUR_MAX = HOUR_MOD
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              clear,
   input  logic              mode_down,
   input  logic              load,
   input  logic [MSEC_W-1:0] load_msec,
   input  logic [SEC_W-1:0]  load_sec,
   input  logic [MIN_W-1:0]  load_min,
   input  logic [HOUR_W-1:0] load_hour,
   input  logic              lap,
   input  logic              lap_show,
   input  logic              option,
   output logic [MSEC_W-1:0] low_digit,
   output logic [SEC_W-1:0]  high_digit,
   output logic              rollover,
   output logic              done
);

   localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
   localparam int PW  = $clog2(DIV);

   logic [PW-1:0]     r_pre;
   logic              r_tick;
   logic              r_done;
   logic              r_roll;
   logic              r_mode_q;
   sw_time_t          r_lap;
   sw_time_t          w_live;
   sw_time_t          w_src;
   logic [MSEC_W-1:0] w_msec;
   logic [SEC_W-1:0]  w_sec;
   logic [MIN_W-1:0]  w_min;
   logic [HOUR_W-1:0] w_hour;
   logic [3:0]        w_c;
   logic              w_mode_chg;
   logic              w_tick_en;
   logic              w_hi_zero;
   logic              w_hold;
   logic              w_step;
   logic              w_done_set;

   assign w_live     = {w_hour, w_min, w_sec, w_msec};
   assign w_mode_chg = mode_down ^ r_mode_q;
   assign w_tick_en  = r_tick & ~r_done & ~clear & ~load;
   assign w_hi_zero  = (w_hour == '0) & (w_min == '0) & (w_sec == '0);
   // A down tick at all-zero must not underflow; it only raises done
   assign w_hold     = mode_down & w_hi_zero & (w_msec == '0);
   assign w_step     = w_tick_en & ~w_hold;
   assign w_done_set = w_tick_en & mode_down & w_hi_zero & (w_msec <= MSEC_W'(1));

   time_field_counter #(.MAX(MSEC_MAX), .WIDTH(MSEC_W)) u_msec (
      .clk(clk), .rst(rst), .en(w_step), .dir(mode_down), .load(load),
      .load_val(load_msec), .clr(clear), .value(w_msec), .co(w_c[0]));

   time_field_counter #(.MAX(SEC_MAX), .WIDTH(SEC_W)) u_sec (
      .clk(clk), .rst(rst), .en(w_c[0]), .dir(mode_down), .load(load),
      .load_val(load_sec), .clr(clear), .value(w_sec), .co(w_c[1]));

   time_field_counter #(.MAX(MIN_MAX), .WIDTH(MIN_W)) u_min (
      .clk(clk), .rst(rst), .en(w_c[1]), .dir(mode_down), .load(load),
      .load_val(load_min), .clr(clear), .value(w_min), .co(w_c[2]));

   time_field_counter #(.MAX(HOUR_MAX), .WIDTH(HOUR_W)) u_hour (
      .clk(clk), .rst(rst), .en(w_c[2]), .dir(mode_down), .load(load),
      .load_val(load_hour), .clr(clear), .value(w_hour), .co(w_c[3]));

   // Prescaler: runs while run=1 and not done, holds its phase on pause, registers a 1-cycle tick at terminal count
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_pre  <= '0;
         r_tick <= 1'b0;
      end else if (clear | load) begin
         r_pre  <= '0;
         r_tick <= 1'b0;
      end else if (run & ~r_done) begin
         r_tick <= (r_pre == PW'(DIV - 1));
         r_pre  <= (r_pre == PW'(DIV - 1)) ? '0 : r_pre + 1'b1;
      end else
         r_tick <= 1'b0;

   // Status: sticky done (cleared by clear, load or a direction change), rollover pulse, direction history
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_done   <= 1'b0;
         r_roll   <= 1'b0;
         r_mode_q <= 1'b0;
      end else begin
         r_mode_q <= mode_down;
         r_roll   <= w_c[3] & ~mode_down;
         r_done   <= (clear | load | w_mode_chg) ? 1'b0 : (r_done | w_done_set);
      end

   // Lap snapshot takes the live time as it stands before any same-cycle tick update
   always_ff @(posedge clk or posedge rst)
      if (rst)
         r_lap <= '0;
      else if (clear)
         r_lap <= '0;
      else if (lap)
         r_lap <= w_live;

   assign w_src      = lap_show ? r_lap : w_live;
   assign low_digit  = option ? MSEC_W'(w_src.minute) : w_src.msec;
   assign high_digit = option ? SEC_W'(w_src.hour) : w_src.second;
   assign rollover   = r_roll;
   assign done       = r_done;

endmodule

// File: tb/tb_stopwatch_timer_dp.sv
// tb_stopwatch_timer_dp: scoreboard bench with a total-centisecond reference model
module tb_stopwatch_timer_dp;

   localparam int CLK_HZ  = 1000;
   localparam int TICK_HZ = 100;
   localparam int DIV     = CLK_HZ / TICK_HZ;
   localparam int TOTAL   = 100 * 60 * 60 * 24;

   typedef struct packed {
      logic [6:0] lo;
      logic [5:0] hi;
      logic       roll;
      logic       dn;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst, run, clear, mode_down, load, lap, lap_show, option;
   logic [6:0] ld_ms;
   logic [5:0] ld_s, ld_m;
   logic [4:0] ld_h;
   logic [6:0] lo;
   logic [5:0] hi;
   logic       roll, dn;

   int   pass_cnt = 0;
   int   total_cnt = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   int   m_t, m_lap, m_pre;
   bit   m_tick, m_done, m_roll, m_mode_q;

   stopwatch_timer_dp #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
      .clk(clk), .rst(rst), .run(run), .clear(clear), .mode_down(mode_down),
      .load(load), .load_msec(ld_ms), .load_sec(ld_s), .load_min(ld_m), .load_hour(ld_h),
      .lap(lap), .lap_show(lap_show), .option(option),
      .low_digit(lo), .high_digit(hi), .rollover(roll), .done(dn));

   always #5 clk = ~clk;

   function automatic int sat_time();
      int ms = (ld_ms > 99) ? 99 : int'(ld_ms);
      int s  = (ld_s > 59) ? 59 : int'(ld_s);
      int mi = (ld_m > 59) ? 59 : int'(ld_m);
      int h  = (ld_h > 23) ? 23 : int'(ld_h);
      return ((h * 60 + mi) * 60 + s) * 100 + ms;
   endfunction

   task automatic model_reset();
      m_t = 0; m_lap = 0; m_pre = 0;
      m_tick = 0; m_done = 0; m_roll = 0; m_mode_q = 0;
   endtask

   task automatic model_step();
      int nt, nl, np;
      bit ntk, nd, nr;
      if (rst) begin
         model_reset();
         return;
      end
      nt = m_t; nl = m_lap; np = m_pre; ntk = 0; nd = m_done; nr = 0;
      if (lap) nl = m_t;
      if (clear) begin
         nt = 0; nl = 0; np = 0; nd = 0;
      end else if (load) begin
         nt = sat_time(); np = 0; nd = 0;
      end else begin
         if (m_tick && !m_done) begin
            if (!mode_down) begin
               nt = (m_t + 1) % TOTAL;
               nr = (m_t == TOTAL - 1);
            end else if (m_t == 0)
               nd = 1;
            else begin
               nt = m_t - 1;
               if (nt == 0) nd = 1;
            end
         end
         if (mode_down != m_mode_q) nd = 0;
         if (run && !m_done) begin
            ntk = (m_pre == DIV - 1);
            np  = ntk ? 0 : m_pre + 1;
         end
      end
      m_t = nt; m_lap = nl; m_pre = np; m_tick = ntk; m_done = nd; m_roll = nr;
      m_mode_q = mode_down;
   endtask

   task automatic push_exp();
      int   src = lap_show ? m_lap : m_t;
      int   ms = src % 100, s = (src / 100) % 60, mi = (src / 6000) % 60, h = src / 360000;
      exp_t e;
      e.lo   = 7'(option ? mi : ms);
      e.hi   = 6'(option ? h : s);
      e.roll = m_roll;
      e.dn   = m_done;
      exp_q.push_back(e);
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         push_exp();
         @(posedge clk);
         model_step();
         #1;
         load = 0; lap = 0; clear = 0;
      end
   endtask

   task automatic do_reset();
      rst = 1;
      model_reset();
      cyc(2);
      rst = 0;
   endtask

   task automatic set_load(input int ms, input int s, input int mi, input int h);
      ld_ms = 7'(ms); ld_s = 6'(s); ld_m = 6'(mi); ld_h = 5'(h);
      load = 1;
   endtask

   task automatic chk(input string nm, input int elo, input int ehi, input bit eroll, input bit edone);
      #1;
      total_cnt++;
      if (lo == 7'(elo) && hi == 6'(ehi) && roll == eroll && dn == edone)
         pass_cnt++;
      else
         $display("FAIL %s: got lo=%0d hi=%0d roll=%0b done=%0b, want lo=%0d hi=%0d roll=%0b done=%0b",
                  nm, lo, hi, roll, dn, elo, ehi, eroll, edone);
   endtask

   always @(negedge clk)
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         total_cnt++;
         if ({lo, hi, roll, dn} === mon_e)
            pass_cnt++;
         else
            $display("FAIL scoreboard t=%0t: lo=%0d want %0d, hi=%0d want %0d, roll=%0b want %0b, done=%0b want %0b",
                     $time, lo, mon_e.lo, hi, mon_e.hi, roll, mon_e.roll, dn, mon_e.dn);
      end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; run = 0; clear = 0; mode_down = 0; load = 0; lap = 0; lap_show = 0; option = 0;
      ld_ms = 0; ld_s = 0; ld_m = 0; ld_h = 0;
      model_reset();
      @(posedge clk);
      model_step();
      #1;
      cyc(2);
      rst = 0;
      chk("reset", 0, 0, 0, 0);

      run = 1; cyc(11); chk("presc_first", 1, 0, 0, 0);
      run = 0; cyc(7);  chk("presc_pause", 1, 0, 0, 0);
      run = 1; cyc(10); chk("presc_resume", 2, 0, 0, 0);

      run = 0; set_load(99, 59, 59, 23); cyc(1);
      chk("wrap_loaded", 99, 59, 0, 0);
      run = 1; cyc(11); chk("wrap", 0, 0, 1, 0);
      option = 1; chk("wrap_hm", 0, 0, 1, 0);
      option = 0; cyc(1); chk("wrap_pulse_end", 0, 0, 0, 0);

      mode_down = 1; set_load(1, 1, 0, 0); cyc(1);
      cyc(11);   chk("down_first", 0, 1, 0, 0);
      cyc(1000); chk("down_zero", 0, 0, 0, 1);
      cyc(40);   chk("down_hold", 0, 0, 0, 1);
      set_load(5, 0, 0, 0); cyc(1); chk("reload_clears_done", 5, 0, 0, 0);

      set_load(0, 0, 0, 1); cyc(1);
      option = 1; chk("borrow_pre", 0, 1, 0, 0);
      cyc(10); chk("borrow_still", 0, 1, 0, 0);
      cyc(1);  chk("borrow_hm", 59, 0, 0, 0);
      option = 0; chk("borrow_sms", 99, 59, 0, 0);

      run = 0; mode_down = 0; set_load(120, 63, 61, 30); cyc(1);
      chk("sat_sms", 99, 59, 0, 0);
      option = 1; chk("sat_hm", 59, 23, 0, 0);
      clear = 1; set_load(50, 30, 30, 10); cyc(1);
      chk("clr_ld_hm", 0, 0, 0, 0);
      option = 0; chk("clr_ld_sms", 0, 0, 0, 0);

      run = 1; set_load(41, 5, 0, 0); cyc(1);
      cyc(20); chk("lap_pre", 42, 5, 0, 0);
      lap = 1; cyc(1); chk("lap_live", 43, 5, 0, 0);
      lap_show = 1; chk("lap_held", 42, 5, 0, 0);
      run = 0; clear = 1; cyc(1); chk("lap_clr", 0, 0, 0, 0);
      lap_show = 0;

      mode_down = 1'($urandom_range(0, 1));
      for (int i = 0; i < 3000; i++) begin
         run = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 299) == 0) mode_down = ~mode_down;
         clear = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 79) == 0) begin
            case ($urandom_range(0, 2))
               0: set_load(127, 63, 63, 31);
               1: set_load($urandom_range(0, 20), 0, 0, 0);
               default: set_load($urandom_range(0, 127), $urandom_range(0, 63),
                                 $urandom_range(0, 63), $urandom_range(0, 31));
            endcase
         end
         lap = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 7) == 0) lap_show = ~lap_show;
         if ($urandom_range(0, 7) == 0) option = ~option;
         if ($urandom_range(0, 999) == 0) do_reset();
         else cyc(1);
      end

      run = 0;
      cyc(2);
      repeat (2) @(negedge clk);
      total_cnt++;
      if (exp_q.size() == 0) pass_cnt++;
      else $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
